lcd_panel_receiver: RTL
=======================

# lcd_panel_receiver

Cycle-based model of the character-LCD panel side of the 8-bit parallel HD44780-style bus (`data`/`rs`/`rw`/`en`). It is the responder our `lcd_display` driver writes to. It decodes instruction and data writes on each falling edge of `en`, maintains the display-control state, DDRAM contents, address counter and busy flag, and returns busy/address or DDRAM data on bus reads. A host readback port exposes DDRAM contents to scoreboards and on-chip consumers.

## Interface
- `DDRAM_DEPTH`, 80: number of character cells, indices 0..79.
- `CMD_BUSY_CYCLES`, 1: busy duration after any accepted write or command except clear; must be ≥1.
- `CLEAR_BUSY_CYCLES`, 1: busy duration after Clear Display; must be ≥1.

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  8  bus data from the driver.
- `rs`  in  1  register select: 0 = instruction, 1 = data.
- `rw`  in  1  0 = write, 1 = read.
- `en`  in  1  enable strobe.
- `data_out`  out  8  bus read data.
- `data_oe`  out  1  high while `data_out` drives the bus.
- `busy`  out  1  busy flag.
- `overrun`  out  1  sticky; set when an `en` fall arrives while busy.
- `addr`  out  7  DDRAM address counter, in HD44780 address encoding.
- `display_on`, `cursor_on`, `blink_on`  out  1 each  Display Control bits D/C/B.
- `if_8bit`, `two_line`, `font_5x10`  out  1 each  Function Set bits DL/N/F.
- `incr`  out  1  Entry Mode I/D bit.
- `rd_index`  in  7  host readback cell index.
- `rd_char`  out  8  contents of cell `rd_index`.

## Operation
- **Edge detect:** `en_q` registers `en`. The fall event is `en_q & ~en`. On the fall cycle, `rs`, `rw` and `data_in` are sampled and the resulting state updates at that edge.
- **Busy gating:**
  - A fall while `busy=1` is dropped and sets `overrun`.
  - Any accepted fall starts busy for `CMD_BUSY_CYCLES`, or `CLEAR_BUSY_CYCLES` for a clear.
  - The busy counter is cleared by reset only.
- **Instruction write (`rs=0`, `rw=0`)**, decoded by the highest set bit:
  - `0x01` Clear: all cells invalidated in one cycle via a per-cell valid bitmap; `addr`=0; `incr`=1.
  - `0x02`/`0x03` Home: `addr`=0.
  - `0x04`–`0x07` Entry Mode: `incr`=bit1. Bit0 (shift) is ignored.
  - `0x08`–`0x0F` Display Control: `display_on`/`cursor_on`/`blink_on` = bits 2/1/0.
  - `0x10`–`0x1F` Shift: if bit3=0, the cursor moves +1 when bit2=1, else −1. Display shift (bit3=1) is accepted with no effect.
  - `0x20`–`0x3F` Function Set: DL/N/F = bits 4/3/2. DL=0 is recorded only; the bus stays 8-bit.
  - `0x40`–`0x7F` CGRAM address: accepted, no effect.
  - `0x80`–`0xFF` Set DDRAM address: `addr`=bits[6:0], normalized as described below.
- **Data write (`rs=1`, `rw=0`):** store `data_in` at cell index(`addr`), set its valid bit, then step `addr`.
- **Status read (`rs=0`, `rw=1`):** `data_out`={`busy`,`addr`}. No state change. Not gated by busy and does not set busy.
- **Data read (`rs=1`, `rw=1`):** `data_out`=cell(`addr`). On the fall, `addr` steps. Gated by busy like a write.
- **Address mapping:**
  - One-line (`two_line=0`): index=`addr`, valid range 0..79. Step wraps 79↔0. A set to ≥80 yields 0.
  - Two-line: ranges 0x00–0x27 and 0x40–0x67; index = line×40 + column. Increment wraps 0x27→0x40 and 0x67→0x00; decrement is the reverse. A set with column ≥40 yields that line's base address.
  - Changing N does not re-normalize `addr`.
- **Invalid cells:** read as 0x20 on both `data_out` and `rd_char`.
- **Reset values:**
  - `addr`=0, `incr`=1, `if_8bit`=1.
  - `display_on`, `cursor_on`, `blink_on`, `two_line`, `font_5x10`, `busy`, `overrun` = 0.
  - `data_out`=0x00, `data_oe`=0.
  - All cells invalid.

## Timing
- Write effects (`addr`, control bits, cell contents) are visible the cycle after the fall cycle.
- `busy` rises the cycle after the fall and stays high exactly N cycles.
- The driver's minimum spacing (one fall every 2 cycles) is accepted when N=1.
- `data_oe` and `data_out` are registered:
  - `data_oe`=1 from the cycle after `en` is sampled high with `rw=1`, through the fall cycle.
  - `data_oe` drops the cycle after the fall.
  - `data_out` tracks the live status or cell value while `data_oe`=1.
- `rd_char` is registered with 1-cycle latency from `rd_index`. An index ≥`DDRAM_DEPTH` returns 0x20.
- A write to cell k and a `rd_index`=k request in the same cycle return the new value one cycle later.
- Reset mid-operation: every output takes its reset value asynchronously. A pending busy count is discarded.

## Test plan
- **Reset/idle:** deassert `reset_n` with `en` low → all outputs at reset values; `rd_char`=0x20 for indices 0, 40, 79.
- **Driver init and write:** 0x38, 0x0C, 0x01, then data 'A' and 'B' at 2-cycle spacing → `if_8bit`=1, `two_line`=1, `display_on`=1, `cursor_on`=0; `rd_char`[0]=0x41, [1]=0x42; `addr`=2; `overrun`=0.
- **Two-line wrap:**
  - Set 0xA7 and write 'x' → cell 39=0x78, `addr`=0x40.
  - Set 0xE7 and write 'y' → cell 79=0x79, `addr`=0x00.
- **Decrement wrap:** entry mode 0x04 at `addr` 0, write 'z' → cell 0=0x7A; `addr`=0x67 in two-line, 79 in one-line.
- **Overrun:** with `CLEAR_BUSY_CYCLES`=5, a clear followed by a write fall 2 cycles later → write dropped, `overrun`=1, status read shows `data_out`[7]=1; the cell stays 0x20.
- **Reset mid-operation:** `reset_n` low during busy after a data write → `busy`=0 and `addr`=0 immediately; all cells read 0x20 after release.

Source files
------------

// File: rtl/lcd_panel_receiver.sv
// HD44780-style character panel responder: decodes bus writes/reads on each en fall; state updates 1 cycle after the fall.
// A fall while busy is dropped and flags overrun; rd_char/data_out are registered with 1-cycle latency.
module lcd_panel_receiver #(
  parameter int DDRAM_DEPTH       = 80,
  parameter int CMD_BUSY_CYCLES   = 1,
  parameter int CLEAR_BUSY_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       rs,
  input  logic       rw,
  input  logic       en,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       busy,
  output logic       overrun,
  output logic [6:0] addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       if_8bit,
  output logic       two_line,
  output logic       font_5x10,
  output logic       incr,
  input  logic [6:0] rd_index,
  output logic [7:0] rd_char
);

  localparam logic [6:0]  DEPTH7 = 7'(DDRAM_DEPTH);
  localparam logic [5:0]  LINE6  = 6'(DDRAM_DEPTH / 2);
  localparam logic [15:0] CMD_N  = 16'(CMD_BUSY_CYCLES);
  localparam logic [15:0] CLR_N  = 16'(CLEAR_BUSY_CYCLES);

  logic              en_q;
  logic [15:0]       busy_cnt;
  logic [7:0]        mem [DDRAM_DEPTH];
  logic [DDRAM_DEPTH-1:0] valid;

  logic       fall, status_rd, gated_fall, accept;
  logic       is_clear, data_wr, data_rd;
  logic [6:0] cur_idx;
  logic       cur_ok;
  logic [7:0] cur_char;

  assign fall       = en_q & ~en;
  assign status_rd  = ~rs & rw;
  assign gated_fall = fall & ~status_rd;
  assign busy       = (busy_cnt != 16'd0);
  assign accept     = gated_fall & ~busy;
  assign is_clear   = accept & ~rs & ~rw & (data_in == 8'h01);
  assign data_wr    = accept & rs & ~rw;
  assign data_rd    = accept & rs & rw;

  // Two-line mode packs line 1 (0x40..) directly after line 0 in the cell array.
  always_comb begin
    cur_idx = addr;
    if (two_line) begin
      if (addr[6]) cur_idx = {1'b0, LINE6} + {1'b0, addr[5:0]};
      else         cur_idx = {1'b0, addr[5:0]};
    end
  end

  assign cur_ok   = (cur_idx < DEPTH7);
  assign cur_char = (cur_ok && valid[cur_idx]) ? mem[cur_idx] : 8'h20;

  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up, input logic two);
    logic [6:0] r;
    if (two) begin
      if (up) r = (a[5:0] >= LINE6 - 6'd1) ? (a[6] ? 7'h00 : 7'h40) : a + 7'd1;
      else    r = (a[5:0] == 6'd0) ? {~a[6], LINE6 - 6'd1} : a - 7'd1;
    end else begin
      if (up) r = (a >= DEPTH7 - 7'd1) ? 7'd0 : a + 7'd1;
      else    r = (a == 7'd0) ? DEPTH7 - 7'd1 : a - 7'd1;
    end
    return r;
  endfunction

  function automatic logic [6:0] norm_addr(input logic [6:0] v, input logic two);
    logic [6:0] r;
    if (two) r = (v[5:0] >= LINE6) ? {v[6], 6'd0} : v;
    else     r = (v >= DEPTH7) ? 7'd0 : v;
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q       <= 1'b0;
      busy_cnt   <= 16'd0;
      overrun    <= 1'b0;
      addr       <= 7'd0;
      incr       <= 1'b1;
      display_on <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      if_8bit    <= 1'b1;
      two_line   <= 1'b0;
      font_5x10  <= 1'b0;
      data_oe    <= 1'b0;
      data_out   <= 8'h00;
      valid      <= '0;
    end else begin
      en_q    <= en;
      data_oe <= en & rw;
      if (en & rw) data_out <= rs ? cur_char : {busy, addr};

      if (accept)    busy_cnt <= is_clear ? CLR_N : CMD_N;
      else if (busy) busy_cnt <= busy_cnt - 16'd1;

      if (gated_fall & busy) overrun <= 1'b1;

      if (data_wr) begin
        if (cur_ok) valid[cur_idx] <= 1'b1;
        addr <= step_addr(addr, incr, two_line);
      end

      if (data_rd) addr <= step_addr(addr, incr, two_line);

      if (accept & ~rs & ~rw) begin
        casez (data_in)
          8'b1???????: addr <= norm_addr(data_in[6:0], two_line);
          8'b01??????: ;
          8'b001?????: begin
            if_8bit   <= data_in[4];
            two_line  <= data_in[3];
            font_5x10 <= data_in[2];
          end
          8'b0001????: if (!data_in[3]) addr <= step_addr(addr, data_in[2], two_line);
          8'b00001???: begin
            display_on <= data_in[2];
            cursor_on  <= data_in[1];
            blink_on   <= data_in[0];
          end
          8'b000001??: incr <= data_in[1];
          8'b0000001?: addr <= 7'd0;
          8'b00000001: begin
            valid <= '0;
            addr  <= 7'd0;
            incr  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (data_wr && cur_ok) mem[cur_idx] <= data_in;
  end

  // Same-cycle bus write/clear is forwarded so readback never returns stale data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_char <= 8'h20;
    end else if (rd_index >= DEPTH7 || is_clear) begin
      rd_char <= 8'h20;
    end else if (data_wr && cur_ok && cur_idx == rd_index) begin
      rd_char <= data_in;
    end else if (valid[rd_index]) begin
      rd_char <= mem[rd_index];
    end else begin
      rd_char <= 8'h20;
    end
  end

endmodule
